// File: rtl/lfm_nco_pkg.sv
// Shared types, constants and table helpers for the chirp-capable I/Q NCO.
package lfm_nco_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam int NCO_LAT = 3;

  function automatic int lut_depth(input int addr_w);
    return 32'sd1 <<< (addr_w - 32'sd2);
  endfunction

  // Half-sample offset keeps sin/cos symmetric so quadrant folding is exact.
  function automatic int sine_entry(input int k, input int addr_w, input int data_w);
    real amp;
    real ang;
    real v;
    amp = real'((32'sd1 <<< (data_w - 32'sd1)) - 32'sd1);
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(32'sd1 <<< addr_w);
    v   = amp * $sin(ang);
    if (v >= 0.0) begin
      return $rtoi(v + 0.5);
    end else begin
      return -$rtoi(0.5 - v);
    end
  endfunction

endpackage

// File: rtl/lfm_iq_nco_lut.sv
// Quarter-wave sine table with two synchronous read ports (ROM-style, no reset).
module quarter_sine_lut
  import lfm_nco_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic [ADDR_W-3:0]        addr_a_i,
  input  logic [ADDR_W-3:0]        addr_b_i,
  output logic signed [DATA_W-1:0] data_a_o,
  output logic signed [DATA_W-1:0] data_b_o
);

  localparam int Q = lut_depth(ADDR_W);

  logic signed [DATA_W-1:0] rom_s [Q];

  for (genvar k = 0; k < Q; k++) begin : g_rom
    assign rom_s[k] = DATA_W'(sine_entry(k, ADDR_W, DATA_W));
  end

  // Registered reads on both ports.
  always_ff @(posedge clk) begin
    data_a_o <= rom_s[addr_a_i];
    data_b_o <= rom_s[addr_b_i];
  end

endmodule

// File: rtl/lfm_iq_nco.sv
// Burst I/Q generator: phase/FCW accumulators, optional chirp, quarter-wave
// folding and a gated output of pulse_len samples per accepted start.
module lfm_iq_nco
  import lfm_nco_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12,
  parameter int LEN_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic [PHASE_W-1:0]       fcw_start,
  input  logic [PHASE_W-1:0]       chirp_rate,
  input  logic [PHASE_W-1:0]       phase_off,
  input  logic [LEN_W-1:0]         pulse_len,
  output logic                     busy,
  output logic                     done,
  output logic                     valid,
  output logic signed [DATA_W-1:0] i_out,
  output logic signed [DATA_W-1:0] q_out
);

  localparam int IDX_W = ADDR_W - 2;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   fcw_q, fcw_d;
  logic [PHASE_W-1:0]   rate_q, rate_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 issue_s, last_issue_s;

  logic                 v1_q, last1_q;
  logic [ADDR_W-1:0]    addr1_q;
  logic [IDX_W-1:0]     idx1_s;
  logic                 v2_q, last2_q;
  logic [1:0]           quad2_q;
  logic signed [DATA_W-1:0] a_s, b_s, i_fold_s, q_fold_s;
  logic                 v3_q, last3_q;
  logic signed [DATA_W-1:0] i3_q, q3_q;

  logic                 busy_q, done_q, valid_q;
  logic signed [DATA_W-1:0] i_q, q_q;

  assign idx1_s = addr1_q[IDX_W-1:0];

  // Next-state, accumulator and sample-issue logic.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    phase_d      = phase_q;
    fcw_d        = fcw_q;
    rate_d       = rate_q;
    cnt_d        = cnt_q;
    issue_s      = 1'b0;
    last_issue_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (pulse_len != {LEN_W{1'b0}})) begin
          mode_d  = mode;
          phase_d = phase_off;
          fcw_d   = fcw_start;
          rate_d  = chirp_rate;
          cnt_d   = pulse_len;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        issue_s      = 1'b1;
        last_issue_s = (cnt_q == LEN_W'(1'b1));
        phase_d      = phase_q + fcw_q;
        cnt_d        = cnt_q - LEN_W'(1'b1);
        if (mode_q) begin
          fcw_d = fcw_q + rate_q;
        end else begin
          fcw_d = fcw_q;
        end
        if (last_issue_s) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (done_q) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      phase_q <= {PHASE_W{1'b0}};
      fcw_q   <= {PHASE_W{1'b0}};
      rate_q  <= {PHASE_W{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      fcw_q   <= fcw_d;
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
    end
  end

  quarter_sine_lut #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lut (
    .clk      (clk),
    .addr_a_i (idx1_s),
    .addr_b_i (~idx1_s),
    .data_a_o (a_s),
    .data_b_o (b_s)
  );

  // Quadrant folding: a is sin of the in-quadrant angle, b its complement.
  always_comb begin
    i_fold_s = b_s;
    q_fold_s = a_s;
    case (quad2_q)
      QUAD_0:  begin q_fold_s = a_s;  i_fold_s = b_s;  end
      QUAD_1:  begin q_fold_s = b_s;  i_fold_s = -a_s; end
      QUAD_2:  begin q_fold_s = -a_s; i_fold_s = -b_s; end
      QUAD_3:  begin q_fold_s = -b_s; i_fold_s = a_s;  end
      default: begin q_fold_s = a_s;  i_fold_s = b_s;  end
    endcase
  end

  // Address, LUT-tag and fold stages plus the gated output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      addr1_q <= {ADDR_W{1'b0}};
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      quad2_q <= 2'd0;
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
      i3_q    <= {DATA_W{1'b0}};
      q3_q    <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      i_q     <= {DATA_W{1'b0}};
      q_q     <= {DATA_W{1'b0}};
    end else begin
      v1_q    <= issue_s;
      last1_q <= last_issue_s;
      addr1_q <= phase_q[PHASE_W-1 -: ADDR_W];
      v2_q    <= v1_q;
      last2_q <= last1_q;
      quad2_q <= addr1_q[ADDR_W-1 -: 2];
      v3_q    <= v2_q;
      last3_q <= last2_q;
      i3_q    <= i_fold_s;
      q3_q    <= q_fold_s;
      valid_q <= v3_q;
      done_q  <= v3_q && last3_q;
      busy_q  <= (state_q != IDLE) && !done_q;
      i_q     <= v3_q ? i3_q : {DATA_W{1'b0}};
      q_q     <= v3_q ? q3_q : {DATA_W{1'b0}};
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign i_out = i_q;
  assign q_out = q_q;

endmodule

// File: doc/lfm_iq_nco.md
Name: lfm_iq_nco

Overview:
Parametrised I/Q waveform generator for the pulse-compression chain. It supersedes the full-cycle dual-port sine/cos ROM that needed an external address counter and quarter-period offset. Contains its own phase accumulator, optional linear-FM (chirp) frequency ramp, programmable start phase and quarter-wave LUT folding. Emits a gated burst of pulse_len I/Q samples per start request for the transmit reference and matched-filter coefficient path.

Parameters:
PHASE_W, 32, phase accumulator and tuning-word width
ADDR_W, 10, full-cycle LUT address bits (N = 2^ADDR_W points per cycle; stored quarter table depth Q = 2^(ADDR_W-2))
DATA_W, 12, signed output sample width
LEN_W, 16, pulse length counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request, sampled only in IDLE
mode  in  1  0 = CW (fixed frequency), 1 = LFM chirp
fcw_start  in  PHASE_W  initial frequency control word (unsigned, turns/sample × 2^PHASE_W)
chirp_rate  in  PHASE_W  signed per-sample FCW increment, used when mode=1
phase_off  in  PHASE_W  initial phase
pulse_len  in  LEN_W  number of samples in the burst
busy  out  1  burst in progress
done  out  1  one-cycle pulse on the last valid sample
valid  out  1  i_out/q_out hold a sample
i_out  out  DATA_W  signed cosine sample
q_out  out  DATA_W  signed sine sample

Behaviour:
- Reset: busy, done and valid are 0. i_out and q_out are 0. State is IDLE. Accumulators and pipeline-valid bits are cleared. Reset asserted mid-burst aborts the burst with no done.
- FSM IDLE -> RUN -> FLUSH -> IDLE.
  - IDLE: on start with pulse_len != 0, latch mode, fcw_start, chirp_rate, phase_off and pulse_len. Set phase = phase_off and fcw = fcw_start. Go to RUN.
  - start with pulse_len == 0 is ignored.
  - start while busy is ignored.
- RUN: each cycle issues one sample address from the current phase, then updates:
  - phase <= phase + fcw, modulo 2^PHASE_W.
  - fcw <= fcw + chirp_rate if mode=1, modulo 2^PHASE_W in two's complement. fcw is unchanged if mode=0.
  - After pulse_len issues, go to FLUSH.
- FLUSH: wait until the pipeline drains, which is the cycle done is asserted, then go to IDLE.
- busy: high from the edge after start is sampled through the cycle done is high inclusive.
- Pipeline, 3 registered stages:
  1. addr = phase[PHASE_W-1 -: ADDR_W]; quad = addr[ADDR_W-1:ADDR_W-2]; idx = addr[ADDR_W-3:0].
  2. Synchronous LUT read at idx and ~idx (two read ports).
  3. Sign and select per quadrant.
- Latency: first valid is 4 edges after the edge sampling start. valid is contiguous for exactly pulse_len cycles.
- LUT content: lut[k] = round((2^(DATA_W-1)-1) × sin(2π(k+0.5)/N)), k = 0..Q-1. The half-sample offset makes folding exact.
- Folding, with a = lut[idx] and b = lut[~idx]:
  - quad 0: q = a, i = b.
  - quad 1: q = b, i = -a.
  - quad 2: q = -a, i = -b.
  - quad 3: q = -b, i = a.
  - Negation cannot overflow because the table maximum is 2^(DATA_W-1)-1.
- i_out and q_out are forced to 0 whenever valid=0.

Decomposition:
- Package lfm_nco_pkg holds:
  - state enum {IDLE, RUN, FLUSH};
  - quadrant constants;
  - LUT depth function Q(ADDR_W);
  - pipeline latency constant NCO_LAT = 3.
- Sub-module quarter_sine_lut: two synchronous read ports, DATA_W × Q entries. It is initialised by a generate-time function or a memory init file so it can map to block RAM.

Test Plan:
- CW quadrature (defaults): mode=0, fcw_start=0x40000000, phase_off=0, pulse_len=4. Required (I,Q) = (2047,6), (-6,2047), (-2047,-6), (6,-2047). done is high with the 4th sample. busy drops after done.
- Latency and framing: start at edge k, pulse_len=1. valid and done are both high only at edge k+4. busy is high for edges k+1..k+4.
- Phase offset wrap: phase_off=0xC0000000, fcw_start=0x40000000, pulse_len=2. Required (I,Q) = (6,-2047), (2047,6).
- LFM: mode=1, fcw_start=0, chirp_rate=0x00100000, pulse_len=1024. Sample n must match a reference model with phase = n(n-1)/2 × rate mod 2^32, exactly. valid has no gaps.
- Protocol robustness: start pulsed during RUN -> ignored, and sample count stays at the original pulse_len. start with pulse_len=0 -> busy stays 0 and no valid.
- Reset mid-burst: rst asserted at sample 100 of 1024 -> busy, valid, done, i_out and q_out are 0 immediately (asynchronous). A new start after release produces a full burst from phase_off.
